fft_mem_ctrl: RTL and testbench

- Sequencer for an in-place radix-2 DIT FFT held in the dual-port FFT working RAM (N words, DW bits, 1-cycle registered read on both ports).
- For every stage and every butterfly it reads the operand pair (port A = top, port B = bottom) and pulses the external butterfly unit with the matching twiddle index.
- After the butterfly latency it writes the two results back to the same addresses.
- Input data is already in bit-reversed order in RAM when start is raised. Output is natural order in RAM when done pulses.

---
 rtl/fft_consts.sv | 16 +
 rtl/fft_addr_gen.sv | 33 +++
 rtl/fft_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fft_mem_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_consts.sv
// Shared constants and types for the in-place radix-2 FFT datapath.
//   N              : FFT size (words in the working RAM)
//   DW             : RAM word width
//   LOG2N          : number of stages / address width
//   BF_LAT_DEFAULT : default butterfly latency in cycles
//   fft_ctrl_state_t : sequencer states
package fft_consts;

  localparam int unsigned N              = 8;
  localparam int unsigned DW             = 32;
  localparam int unsigned LOG2N          = $clog2(N);
  localparam int unsigned BF_LAT_DEFAULT = 2;

  typedef enum logic [2:0] {IDLE, RD, WT, WR, FIN} fft_ctrl_state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 DIT address generator.
// Maps (stage s, butterfly index k) to the operand pair and twiddle index:
//   stage   in  LOG2N    stage index s
//   k       in  LOG2N-1  butterfly index within the stage
//   top     out LOG2N    top operand address
//   bot     out LOG2N    bottom operand address (top + 2^s)
//   tw_addr out LOG2N-1  twiddle ROM index
module fft_addr_gen
  import fft_consts::*;
(
  input  logic [LOG2N-1:0] stage,
  input  logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] top,
  output logic [LOG2N-1:0] bot,
  output logic [LOG2N-2:0] tw_addr
);

  logic [LOG2N-1:0] kx;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] j;

  always_comb begin
    kx   = LOG2N'(k);
    half = LOG2N'(1) << stage;
    j    = kx & (half - 1'b1);
    // Group index k>>s selects a block of 2*half words; j is the offset inside it.
    top  = ((kx >> stage) << (stage + 1'b1)) | j;
    bot  = top + half;
    // j < half, so the shifted value always fits in LOG2N-1 bits.
    tw_addr = (LOG2N - 1)'(j << (LOG2N'(LOG2N - 1) - stage));
  end

endmodule

// File: rtl/fft_mem_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT in a dual-port RAM with
// 1-cycle registered reads. For each stage and butterfly it reads the
// operand pair, pulses the butterfly unit, and writes the results back to
// the same addresses BF_LAT cycles later.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : 1-cycle run request, ignored unless idle
//   busy, done           : run in progress / 1-cycle completion pulse
//   stage                : current stage for the butterfly scaling shift
//   ram_ena/wea/addra    : port A (top operand)
//   ram_enb/web/addrb    : port B (bottom operand)
//   tw_addr              : twiddle ROM index
//   bf_go                : RAM outputs hold valid operands this cycle
module fft_mem_ctrl
  import fft_consts::*;
#(
  parameter int unsigned BF_LAT = BF_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             ram_ena,
  output logic             ram_wea,
  output logic [LOG2N-1:0] ram_addra,
  output logic             ram_enb,
  output logic             ram_web,
  output logic [LOG2N-1:0] ram_addrb,
  output logic [LOG2N-2:0] tw_addr,
  output logic             bf_go
);

  localparam int unsigned     KW      = LOG2N - 1;
  localparam int unsigned     CW      = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [KW-1:0]   KLast   = KW'(N / 2 - 1);
  localparam logic [LOG2N-1:0] SLast  = LOG2N'(LOG2N - 1);
  localparam logic [CW-1:0]   CntLast = CW'(BF_LAT - 1);

  fft_ctrl_state_t state_q;
  logic [KW-1:0]    k_q;
  logic [CW-1:0]    cnt_q;

  logic [LOG2N-1:0] nxt_stage;
  logic [KW-1:0]    nxt_k;
  logic             last_k;
  logic             last_bf;
  logic [LOG2N-1:0] gen_top;
  logic [LOG2N-1:0] gen_bot;
  logic [KW-1:0]    gen_tw;

  // Indices of the butterfly entered next. Outside WR this is (0,0), which is
  // what a launch from IDLE needs; addresses are then registered so they stay
  // stable from RD through WR.
  always_comb begin
    nxt_stage = '0;
    nxt_k     = '0;
    last_k    = (k_q == KLast);
    last_bf   = last_k && (stage == SLast);
    if (state_q == WR) begin
      if (last_k) begin
        nxt_stage = stage + 1'b1;
      end else begin
        nxt_stage = stage;
        nxt_k     = k_q + 1'b1;
      end
    end
  end

  fft_addr_gen u_addr_gen (
    .stage   (nxt_stage),
    .k       (nxt_k),
    .top     (gen_top),
    .bot     (gen_bot),
    .tw_addr (gen_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      ram_ena   <= 1'b0;
      ram_wea   <= 1'b0;
      ram_addra <= '0;
      ram_enb   <= 1'b0;
      ram_web   <= 1'b0;
      ram_addrb <= '0;
      tw_addr   <= '0;
      bf_go     <= 1'b0;
    end else begin
      done  <= 1'b0;
      bf_go <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RD;
            busy      <= 1'b1;
            k_q       <= nxt_k;
            stage     <= nxt_stage;
            ram_addra <= gen_top;
            ram_addrb <= gen_bot;
            tw_addr   <= gen_tw;
            ram_ena   <= 1'b1;
            ram_enb   <= 1'b1;
          end
        end
        RD: begin
          state_q <= WT;
          cnt_q   <= '0;
          ram_ena <= 1'b0;
          ram_enb <= 1'b0;
          // Read data appears on the RAM outputs one cycle after RD.
          bf_go   <= 1'b1;
        end
        WT: begin
          if (cnt_q == CntLast) begin
            state_q <= WR;
            ram_ena <= 1'b1;
            ram_enb <= 1'b1;
            ram_wea <= 1'b1;
            ram_web <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WR: begin
          ram_wea <= 1'b0;
          ram_web <= 1'b0;
          if (last_bf) begin
            state_q   <= FIN;
            busy      <= 1'b0;
            done      <= 1'b1;
            ram_ena   <= 1'b0;
            ram_enb   <= 1'b0;
            k_q       <= '0;
            stage     <= '0;
            ram_addra <= '0;
            ram_addrb <= '0;
            tw_addr   <= '0;
          end else begin
            // Enables stay high: the next cycle is the read of the next pair.
            state_q   <= RD;
            k_q       <= nxt_k;
            stage     <= nxt_stage;
            ram_addra <= gen_top;
            ram_addrb <= gen_bot;
            tw_addr   <= gen_tw;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_mem_ctrl.sv
// Bench for fft_mem_ctrl: three instances (BF_LAT = 2, 3, 1) checked every
// cycle against a closed-form timing model, plus directed literal checks,
// and an end-to-end impulse FFT through a RAM and complex butterfly on the
// BF_LAT = 2 instance.
module tb_fft_mem_ctrl;
  import fft_consts::*;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic [LOG2N-1:0] stage;
    logic             ena;
    logic             wea;
    logic [LOG2N-1:0] addra;
    logic             enb;
    logic             web;
    logic [LOG2N-1:0] addrb;
    logic [LOG2N-2:0] tw;
    logic             bf_go;
  } obs_t;

  localparam logic [DW-1:0] Imp = {16'd1000, 16'd0};

  logic clk = 1'b0;
  logic rst_n;
  logic start_v [3];
  logic load_imp;
  logic chk_en = 1'b0;
  logic rec_en = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [2:0]             busy, done, ena, wea, enb, web, bf_go;
  logic [2:0][LOG2N-1:0]  stage, addra, addrb;
  logic [2:0][LOG2N-2:0]  tw;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 2 : (g == 1) ? 3 : 1;
    fft_mem_ctrl #(.BF_LAT(Lat)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_v[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .stage     (stage[g]),
      .ram_ena   (ena[g]),
      .ram_wea   (wea[g]),
      .ram_addra (addra[g]),
      .ram_enb   (enb[g]),
      .ram_web   (web[g]),
      .ram_addrb (addrb[g]),
      .tw_addr   (tw[g]),
      .bf_go     (bf_go[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- Timing model ----------------
  // t = cycles since the first read of a run (-1 when idle). Each butterfly
  // spans lat+2 cycles: read, lat waits, write. The cycle after the last
  // butterfly is the done pulse.
  function automatic int total_of(input int lat);
    return LOG2N * (N / 2) * (lat + 2);
  endfunction

  function automatic obs_t model_out(input int lat, input int t);
    obs_t o;
    int per, b, p, s, k, half, j, base;
    o = '0;
    per = lat + 2;
    if (t < 0) return o;
    if (t == total_of(lat)) begin
      o.done = 1'b1;
      return o;
    end
    b    = t / per;
    p    = t % per;
    s    = b / (N / 2);
    k    = b % (N / 2);
    half = 1 << s;
    j    = k % half;
    base = (k / half) * 2 * half;
    o.busy  = 1'b1;
    o.stage = LOG2N'(s);
    o.addra = LOG2N'(base + j);
    o.addrb = LOG2N'(base + j + half);
    o.tw    = (LOG2N - 1)'(j * (N / 2) / half);
    o.ena   = (p == 0) || (p == lat + 1);
    o.enb   = o.ena;
    o.wea   = (p == lat + 1);
    o.web   = o.wea;
    o.bf_go = (p == 1);
    return o;
  endfunction

  int run_t [3];
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n)                           run_t[i] <= -1;
      else if (run_t[i] < 0)                run_t[i] <= start_v[i] ? 0 : -1;
      else if (run_t[i] >= total_of(lat_of(i))) run_t[i] <= -1;
      else                                  run_t[i] <= run_t[i] + 1;
    end
  end

  function automatic obs_t obs_of(input int i);
    obs_t o;
    o.busy  = busy[i];
    o.done  = done[i];
    o.stage = stage[i];
    o.ena   = ena[i];
    o.wea   = wea[i];
    o.addra = addra[i];
    o.enb   = enb[i];
    o.web   = web[i];
    o.addrb = addrb[i];
    o.tw    = tw[i];
    o.bf_go = bf_go[i];
    return o;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d_outputs_cycle%0d", i, cyc), 32'(obs_of(i)),
            32'(model_out(lat_of(i), run_t[i])));
      end
    end
  end

  // ---------------- RAM + reference butterfly on instance 0 ----------------
  logic [DW-1:0] mem [N];
  logic [DW-1:0] douta, doutb, res_top, res_bot;

  function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] m);
    int ar, ai, br, bi, wr, wi, pr, pi;
    ar = int'($signed(a[31:16]));
    ai = int'($signed(a[15:0]));
    br = int'($signed(b[31:16]));
    bi = int'($signed(b[15:0]));
    // W8^m = exp(-j*2*pi*m/8) in Q14
    case (m)
      2'd0:    begin wr = 16384;  wi = 0;      end
      2'd1:    begin wr = 11585;  wi = -11585; end
      2'd2:    begin wr = 0;      wi = -16384; end
      default: begin wr = -11585; wi = -11585; end
    endcase
    pr = (br * wr - bi * wi) >>> 14;
    pi = (br * wi + bi * wr) >>> 14;
    return {16'(ar + pr), 16'(ai + pi), 16'(ar - pr), 16'(ai - pi)};
  endfunction

  always @(posedge clk) begin
    if (load_imp) begin
      for (int i = 0; i < N; i++) mem[i] <= (i == 0) ? Imp : '0;
    end else begin
      if (ena[0] && wea[0]) mem[addra[0]] <= res_top;
      if (enb[0] && web[0]) mem[addrb[0]] <= res_bot;
    end
    if (ena[0]) douta <= mem[addra[0]];
    if (enb[0]) doutb <= mem[addrb[0]];
    if (bf_go[0]) {res_top, res_bot} <= bfly(douta, doutb, tw[0]);
  end

  logic [7:0] trace [$];
  always @(negedge clk) begin
    if (rec_en && ena[0] && !wea[0]) trace.push_back({addra[0], addrb[0], tw[0]});
  end

  // ---------------- Stimulus helpers ----------------
  task automatic pulse(input int i, output int sc);
    @(posedge clk); #1;
    start_v[i] = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
  endtask

  task automatic pulse_at(input int i, input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done[i]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk($sformatf("u%0d_done_timeout", i), 32'd0, 32'd1);
  endtask

  logic [7:0] exp_tr [12] = '{
    {3'd0, 3'd1, 2'd0}, {3'd2, 3'd3, 2'd0}, {3'd4, 3'd5, 2'd0}, {3'd6, 3'd7, 2'd0},
    {3'd0, 3'd2, 2'd0}, {3'd1, 3'd3, 2'd2}, {3'd4, 3'd6, 2'd0}, {3'd5, 3'd7, 2'd2},
    {3'd0, 3'd4, 2'd0}, {3'd1, 3'd5, 2'd1}, {3'd2, 3'd6, 2'd2}, {3'd3, 3'd7, 2'd3}
  };

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t m;
    int sc, cd, found;
    rst_n = 1'b1;
    load_imp = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("u%0d_reset_state", i), 32'(obs_of(i)), 32'd0);

    // Hand-computed points that pin the model itself.
    m = model_out(2, 20);
    chk("model_l2_s1k1_rd", {m.stage, m.addra, m.addrb, m.tw, m.ena, m.wea},
        {3'd1, 3'd1, 3'd3, 2'd2, 1'b1, 1'b0});
    m = model_out(3, 48);
    chk("model_l3_s2k1_wt", {m.busy, m.stage, m.addra, m.addrb, m.tw, m.ena, m.bf_go},
        {1'b1, 3'd2, 3'd1, 3'd5, 2'd1, 1'b0, 1'b0});
    m = model_out(2, 48);
    chk("model_l2_fin", 32'(m), 32'(obs_t'{done: 1'b1, default: '0}));

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    load_imp = 1'b1;
    @(posedge clk); #1;
    load_imp = 1'b0;
    rec_en = 1'b1;

    fork
      begin : b_lat2
        int s0, s1, d0, d1;
        pulse(0, s0);
        pulse_at(0, s0 + 5);
        pulse_at(0, s0 + 20);
        wait_done(0, 80, d0);
        rec_en = 1'b0;
        chk("lat2_start_to_done", 32'(d0 - s0), 32'd49);
        for (int i = 0; i < N; i++) chk($sformatf("e2e_word%0d", i), mem[i], Imp);
        pulse(0, s1);
        chk("lat2_restart_busy", 32'(busy[0]), 32'd1);
        wait_done(0, 80, d1);
        chk("lat2_second_run", 32'(d1 - s1), 32'd49);
      end
      begin : b_lat3
        int s0, d0, rd, go, wr;
        rd = -1; go = -1; wr = -1; d0 = -1;
        pulse(1, s0);
        for (int n = 0; n < 100 && d0 < 0; n++) begin
          @(negedge clk);
          if (ena[1] && !wea[1] && rd < 0) rd = cyc;
          if (bf_go[1] && go < 0) go = cyc;
          if (wea[1] && wr < 0) wr = cyc;
          if (done[1]) d0 = cyc;
        end
        chk("lat3_rd_to_bfgo", 32'(go - rd), 32'd1);
        chk("lat3_bfgo_to_wr", 32'(wr - go), 32'd3);
        chk("lat3_start_to_done", 32'(d0 - s0), 32'd61);
      end
      begin : b_lat1
        int s0, s1, d0, d1;
        pulse(2, s0);
        wait_done(2, 60, d0);
        chk("lat1_run1", 32'(d0 - s0), 32'd37);
        pulse(2, s1);
        wait_done(2, 60, d1);
        chk("lat1_run2", 32'(d1 - s1), 32'd37);
      end
    join

    chk("trace_len", 32'(trace.size()), 32'd12);
    for (int i = 0; i < 12 && i < trace.size(); i++)
      chk($sformatf("trace_rd%0d", i), 32'(trace[i]), 32'(exp_tr[i]));

    // Reset in the middle of stage 1, during the wait phase.
    pulse(0, sc);
    found = 0;
    for (int n = 0; n < 60 && found == 0; n++) begin
      @(negedge clk);
      if (stage[0] == 3'd1 && bf_go[0]) found = 1;
    end
    chk("reach_stage1_wt", 32'(found), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(obs_of(0)), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    pulse(0, sc);
    found = -1;
    for (int n = 0; n < 5 && found < 0; n++) begin
      @(negedge clk);
      if (ena[0]) found = cyc;
    end
    chk("restart_first_rd_cycle", 32'(found - sc), 32'd1);
    chk("restart_first_rd", {stage[0], addra[0], addrb[0], tw[0]},
        {3'd0, 3'd0, 3'd1, 2'd0});
    wait_done(0, 80, cd);
    chk("restart_start_to_done", 32'(cd - sc), 32'd49);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
